// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    SYS_HOLD = 2'd1,
    RUN      = 2'd2
  } rst_state_t;

  localparam int unsigned CAUSE_W      = 4;
  localparam int unsigned CAUSE_PIN    = 0;
  localparam int unsigned CAUSE_PLL    = 1;
  localparam int unsigned CAUSE_SYSREQ = 2;
  localparam int unsigned CAUSE_WDOG   = 3;

  // Counter width able to hold the larger of the two hold lengths.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync2.sv
// Generic two-flop bit synchroniser; no reset so it never holds a stale level.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: orders poreset_n before hreset_n, arbitrates reset sources
// and keeps a sticky record of the last cause.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned POR_CYCLES = 255,
  parameter int unsigned SYS_CYCLES = 15
) (
  input  logic               hclk,
  input  logic               RESET,
  input  logic               pll_locked,
  input  logic               sysresetreq,
  input  logic               wdog_rst,
  input  logic               cause_clr,
  output logic               poreset_n,
  output logic               hreset_n,
  output logic [CAUSE_W-1:0] rst_cause,
  output logic               lock_sync
);

  localparam int unsigned CNT_W = cnt_width(POR_CYCLES, SYS_CYCLES);

  rst_state_t         state;
  rst_state_t         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               por_nxt;
  logic               hrst_nxt;
  logic [CAUSE_W-1:0] cause_nxt;
  logic               req;
  logic               cnt_zero;

  assign req      = sysresetreq | wdog_rst;
  assign cnt_zero = (cnt == '0);

  sync2 #(.W(1)) u_lock_sync (
    .clk (hclk),
    .d   (pll_locked),
    .q   (lock_sync)
  );

  // State, counter and registered outputs; RESET overrides everything.
  always_ff @(posedge hclk) begin
    if (RESET) begin
      state     <= POR_HOLD;
      cnt       <= CNT_W'(POR_CYCLES);
      poreset_n <= 1'b0;
      hreset_n  <= 1'b0;
      rst_cause <= CAUSE_W'(1) << CAUSE_PIN;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      poreset_n <= por_nxt;
      hreset_n  <= hrst_nxt;
      rst_cause <= cause_nxt;
    end
  end

  // Next state and counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!lock_sync) begin
      state_nxt = POR_HOLD;
      cnt_nxt   = CNT_W'(POR_CYCLES);
    end else begin
      unique case (state)
        POR_HOLD: begin
          if (cnt_zero) begin
            state_nxt = SYS_HOLD;
            cnt_nxt   = CNT_W'(SYS_CYCLES);
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        SYS_HOLD: begin
          // Once drained, a still-active request keeps the bus in reset.
          if (!cnt_zero) begin
            cnt_nxt = cnt - CNT_W'(1);
          end else if (!req) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (req) begin
            state_nxt = SYS_HOLD;
            cnt_nxt   = CNT_W'(SYS_CYCLES);
          end
        end
        default: begin
          state_nxt = POR_HOLD;
          cnt_nxt   = CNT_W'(POR_CYCLES);
        end
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    por_nxt   = poreset_n;
    hrst_nxt  = hreset_n;
    cause_nxt = rst_cause;
    if (!lock_sync) begin
      por_nxt  = 1'b0;
      hrst_nxt = 1'b0;
      // Only the entry into lock loss records the cause.
      if (state != POR_HOLD) begin
        cause_nxt = CAUSE_W'(1) << CAUSE_PLL;
      end
    end else begin
      unique case (state)
        POR_HOLD: begin
          por_nxt  = cnt_zero;
          hrst_nxt = 1'b0;
        end
        SYS_HOLD: begin
          por_nxt  = 1'b1;
          hrst_nxt = cnt_zero & ~req;
        end
        RUN: begin
          por_nxt = 1'b1;
          if (req) begin
            hrst_nxt                = 1'b0;
            cause_nxt               = '0;
            cause_nxt[CAUSE_WDOG]   = wdog_rst;
            cause_nxt[CAUSE_SYSREQ] = sysresetreq;
          end else if (cause_clr) begin
            cause_nxt = '0;
          end
        end
        default: begin
          por_nxt  = 1'b0;
          hrst_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: directed scenarios plus random traffic
// against a behavioural model that counts qualifying edges.
module tb_rst_seq_ctrl;

  localparam int unsigned POR_CYCLES = 255;
  localparam int unsigned SYS_CYCLES = 15;

  logic       hclk        = 1'b0;
  logic       RESET       = 1'b1;
  logic       pll_locked  = 1'b1;
  logic       sysresetreq = 1'b0;
  logic       wdog_rst    = 1'b0;
  logic       cause_clr   = 1'b0;
  logic       poreset_n;
  logic       hreset_n;
  logic [3:0] rst_cause;
  logic       lock_sync;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          chk_en      = 1'b0;

  always #5 hclk = ~hclk;

  rst_seq_ctrl #(
    .POR_CYCLES (POR_CYCLES),
    .SYS_CYCLES (SYS_CYCLES)
  ) dut (
    .hclk        (hclk),
    .RESET       (RESET),
    .pll_locked  (pll_locked),
    .sysresetreq (sysresetreq),
    .wdog_rst    (wdog_rst),
    .cause_clr   (cause_clr),
    .poreset_n   (poreset_n),
    .hreset_n    (hreset_n),
    .rst_cause   (rst_cause),
    .lock_sync   (lock_sync)
  );

  // Model: poreset_n releases after POR_CYCLES+1 clean edges since the last
  // POR-class event; hreset_n after SYS_CYCLES+1 more edges with no request.
  bit          m_l1 = 1'b1;
  bit          m_l2 = 1'b1;
  bit          m_por = 1'b0;
  bit          m_hrst = 1'b0;
  logic [3:0]  m_cause = 4'b0001;
  int unsigned por_edges = 0;
  int unsigned sys_edges = 0;

  always @(posedge hclk) begin : model
    bit lk;
    bit rq;
    lk   = m_l2;
    m_l2 = m_l1;
    m_l1 = pll_locked;
    rq   = sysresetreq | wdog_rst;
    if (RESET) begin
      por_edges = 0;
      m_por     = 1'b0;
      m_hrst    = 1'b0;
      m_cause   = 4'b0001;
    end else if (!lk) begin
      if (m_por) m_cause = 4'b0010;
      por_edges = 0;
      m_por     = 1'b0;
      m_hrst    = 1'b0;
    end else if (!m_por) begin
      por_edges++;
      if (por_edges == POR_CYCLES + 1) begin
        m_por     = 1'b1;
        sys_edges = 0;
      end
    end else if (!m_hrst) begin
      sys_edges++;
      if (sys_edges > SYS_CYCLES && !rq) m_hrst = 1'b1;
    end else if (rq) begin
      m_hrst    = 1'b0;
      sys_edges = 0;
      m_cause   = {wdog_rst, sysresetreq, 2'b00};
    end else if (cause_clr) begin
      m_cause = 4'b0000;
    end
  end

  always @(negedge hclk) begin : compare
    if (chk_en) begin
      vectors++;
      if ({poreset_n, hreset_n, rst_cause, lock_sync} !== {m_por, m_hrst, m_cause, m_l2}) begin
        miscompares++;
        $display("FAIL model t=%0t: dut por=%b hrst=%b cause=%b lock=%b, expected por=%b hrst=%b cause=%b lock=%b",
                 $time, poreset_n, hreset_n, rst_cause, lock_sync, m_por, m_hrst, m_cause, m_l2);
      end
      vectors++;
      if (hreset_n === 1'b1 && poreset_n !== 1'b1) begin
        miscompares++;
        $display("FAIL order t=%0t: hreset_n=1 while poreset_n=%b, required 1", $time, poreset_n);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Negedges until the chosen reset (0=poreset_n, 1=hreset_n) reads high.
  task automatic wait_high(input int sel, input int limit, output int n);
    n = 0;
    do begin
      @(negedge hclk);
      n++;
    end while (((sel == 0) ? poreset_n : hreset_n) !== 1'b1 && n < limit);
  endtask

  task automatic pulse_req(input logic s, input logic w, input logic c);
    sysresetreq = s;
    wdog_rst    = w;
    cause_clr   = c;
    @(negedge hclk);
    sysresetreq = 1'b0;
    wdog_rst    = 1'b0;
    cause_clr   = 1'b0;
  endtask

  initial begin : stim
    int n;
    int n2;
    repeat (4) @(negedge hclk);
    chk_en = 1'b1;
    check("reset_por", 32'(poreset_n), 0);
    check("reset_hrst", 32'(hreset_n), 0);
    check("reset_cause", 32'(rst_cause), 32'h1);

    // Power-up release timing.
    RESET = 1'b0;
    wait_high(0, 400, n);
    check("por_release", n, 256);
    wait_high(1, 100, n2);
    check("hrst_release", n + n2, 272);
    check("pin_cause", 32'(rst_cause), 32'h1);

    // Lock loss in RUN; count restarts once lock_sync returns.
    pll_locked = 1'b0;
    repeat (10) @(negedge hclk);
    check("loss_por", 32'(poreset_n), 0);
    check("loss_hrst", 32'(hreset_n), 0);
    check("loss_cause", 32'(rst_cause), 32'h2);
    pll_locked = 1'b1;
    wait_high(0, 400, n);
    check("relock_por", n, 258);
    wait_high(1, 100, n2);
    check("relock_hrst", n2, 16);

    // Single-cycle SYSRESETREQ; cause_clr during SYS_HOLD is ignored.
    pulse_req(1'b1, 1'b0, 1'b0);
    check("sysreq_hrst", 32'(hreset_n), 0);
    check("sysreq_por", 32'(poreset_n), 1);
    check("sysreq_cause", 32'(rst_cause), 32'h4);
    pulse_req(1'b0, 1'b0, 1'b1);
    wait_high(1, 100, n);
    check("sysreq_hold", n, 15);
    check("clr_in_hold", 32'(rst_cause), 32'h4);

    // Held watchdog extends hreset_n.
    wdog_rst = 1'b1;
    repeat (40) @(negedge hclk);
    wdog_rst = 1'b0;
    check("wdog_held_hrst", 32'(hreset_n), 0);
    wait_high(1, 100, n);
    check("wdog_release", n, 1);
    check("wdog_cause", 32'(rst_cause), 32'h8);

    // Simultaneous events and clear interaction.
    pulse_req(1'b1, 1'b1, 1'b0);
    check("both_cause", 32'(rst_cause), 32'hC);
    wait_high(1, 100, n);
    pulse_req(1'b1, 1'b0, 1'b1);
    check("clr_vs_sysreq", 32'(rst_cause), 32'h4);
    wait_high(1, 100, n);
    pulse_req(1'b0, 1'b0, 1'b1);
    check("clr_alone", 32'(rst_cause), 32'h0);

    // Mid-sequence RESET reloads the POR counter.
    RESET = 1'b1;
    @(negedge hclk);
    RESET = 1'b0;
    repeat (100) @(negedge hclk);
    RESET = 1'b1;
    repeat (2) @(negedge hclk);
    check("mid_reset_cause", 32'(rst_cause), 32'h1);
    RESET = 1'b0;
    wait_high(0, 400, n);
    check("mid_por_release", n, 256);
    wait_high(1, 100, n2);
    check("mid_hrst_release", n + n2, 272);

    // Random traffic against the model.
    for (int i = 0; i < 8000; i++) begin
      RESET = ($urandom_range(0, 2999) == 0);
      if (pll_locked) pll_locked = ($urandom_range(0, 1999) != 0);
      else            pll_locked = ($urandom_range(0, 7) == 0);
      sysresetreq = ($urandom_range(0, 59) == 0);
      if (wdog_rst) wdog_rst = ($urandom_range(0, 9) != 0);
      else          wdog_rst = ($urandom_range(0, 149) == 0);
      cause_clr = ($urandom_range(0, 9) == 0);
      @(negedge hclk);
    end
    RESET       = 1'b0;
    pll_locked  = 1'b1;
    sysresetreq = 1'b0;
    wdog_rst    = 1'b0;
    cause_clr   = 1'b0;
    repeat (300) @(negedge hclk);
    check("final_run_por", 32'(poreset_n), 1);
    check("final_run_hrst", 32'(hreset_n), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
